// File: rtl/mem_access_ctrl.sv
// Bridges the datapath's single-cycle memory port to a variable-latency req/ack bus.
// Stalls the CPU for the duration of each bus access and flags misaligned or timed-out accesses.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          access, aligned;
  logic          start, ack_done, abort, misalign_hit;

  assign access  = mem_ren | mem_wen;
  assign aligned = (mem_addr[1:0] == 2'b00);

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    ack_done     = 1'b0;
    abort        = 1'b0;
    misalign_hit = 1'b0;
    case (state)
      IDLE: begin
        if (access && aligned) begin
          start     = 1'b1;
          state_nxt = REQ;
        end else if (access) begin
          misalign_hit = 1'b1;
        end
      end
      REQ: begin
        // ack has priority over the timeout on the final allowed cycle
        if (bus_ack) begin
          ack_done  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // gated by rst so the CPU is never frozen while reset is asserted
    stall = !rst && (((state == IDLE) && access && aligned) || (state == REQ));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      mem_din      <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      cnt          <= '0;
    end else begin
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_wen;
        bus_addr  <= {mem_addr[31:2], 2'b00};
        bus_wdata <= mem_dout;
      end
      if (ack_done || abort) begin
        bus_req <= 1'b0;
      end
      if (ack_done && !bus_we) begin
        mem_din <= bus_rdata;
      end
      if (abort) begin
        err_timeout <= 1'b1;
        if (!bus_we) begin
          mem_din <= ERR_RDATA;
        end
      end
      if (misalign_hit) begin
        err_misalign <= 1'b1;
      end
      if ((state == REQ) && !ack_done && !abort) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ren = 1'b0, mem_wen = 1'b0;
  logic [31:0] mem_addr = '0, mem_dout = '0;
  logic [31:0] mem_din;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        err_misalign, err_timeout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] exp_din = '0;
  logic        exp_mis = 1'b0;
  logic        exp_tmo = 1'b0;

  mem_access_ctrl #(.TIMEOUT(TMO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".mem_din"}, mem_din, exp_din);
    check({tag, ".err_mis"}, 32'(err_misalign), 32'(exp_mis));
    check({tag, ".err_tmo"}, 32'(err_timeout), 32'(exp_tmo));
  endtask

  // One aligned access; the slave acks in REQ cycle 'waits' (0-based), never if waits >= TMO.
  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int unsigned waits,
                           input logic [31:0] rdata);
    int unsigned stalls = 0, reqs = 0, bad = 0;
    bit          done = 1'b0;
    bit          timed_out = (waits >= TMO);
    logic        is_wr = wen;
    if (!is_wr) exp_din = timed_out ? ERR : rdata;
    if (timed_out) exp_tmo = 1'b1;
    @(negedge clk);
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata; bus_ack = 1'b0;
    for (int unsigned n = 0; n < 40 && !done; n++) begin
      if (n > 0) begin
        @(negedge clk);
        // scramble the datapath side: it must be ignored until the access retires
        mem_ren = 1'($urandom); mem_wen = 1'($urandom);
        mem_addr = $urandom; mem_dout = $urandom;
      end
      #1;
      if (n > 0 && !stall) begin
        done = 1'b1;
        check("done.bus_req", 32'(bus_req), 32'd0);
        check_flags("done");
        mem_ren = 1'b0; mem_wen = 1'b0;
        bus_ack = 1'($urandom);
        bus_rdata = $urandom;
      end else begin
        if (stall) stalls++;
        if (bus_req) begin
          reqs++;
          if (bus_we !== is_wr || bus_addr !== addr || bus_wdata !== wdata) bad++;
          bus_ack = (reqs - 1 == waits);
          bus_rdata = bus_ack ? rdata : $urandom;
        end else begin
          bus_ack = 1'b0;
        end
      end
    end
    check("completed", 32'(done), 32'd1);
    check("stall_cycles", stalls, timed_out ? TMO + 1 : waits + 2);
    check("req_cycles", reqs, timed_out ? TMO : waits + 1);
    check("req_stable", bad, 0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("after.bus_req", 32'(bus_req), 32'd0);
    check("after.stall", 32'(stall), 32'd0);
    check_flags("after");
  endtask

  task automatic do_misaligned(input logic ren, input logic wen, input logic [31:0] addr);
    @(negedge clk);
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = $urandom;
    #1;
    check("mis.stall", 32'(stall), 32'd0);
    @(negedge clk);
    exp_mis = 1'b1;
    mem_ren = 1'b0; mem_wen = 1'b0;
    #1;
    check("mis.bus_req", 32'(bus_req), 32'd0);
    check_flags("mis");
  endtask

  task automatic stray_ack();
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = $urandom;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("stray.bus_req", 32'(bus_req), 32'd0);
    check("stray.stall", 32'(stall), 32'd0);
    check_flags("stray");
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_0080; bus_ack = 1'b0;
    @(negedge clk);
    mem_ren = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid.in_req", 32'(bus_req), 32'd1);
    mem_ren = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rstmid.bus_req", 32'(bus_req), 32'd0);
    check("rstmid.stall", 32'(stall), 32'd0);
    mem_ren = 1'b0;
    exp_din = '0; exp_mis = 1'b0; exp_tmo = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rstmid.late_ack_req", 32'(bus_req), 32'd0);
    check("rstmid.late_ack_stall", 32'(stall), 32'd0);
    check_flags("rstmid");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem_ren = 1'b1; mem_addr = 32'h0000_0004;
    #12;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.bus_req", 32'(bus_req), 32'd0);
    check("rst.bus_we", 32'(bus_we), 32'd0);
    check("rst.bus_addr", bus_addr, 32'd0);
    check("rst.bus_wdata", bus_wdata, 32'd0);
    check_flags("rst");
    mem_ren = 1'b0; mem_addr = '0;
    @(negedge clk);
    rst = 1'b0;

    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678);
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 5, 32'hFFFF_FFFF);
    do_misaligned(1'b1, 1'b0, 32'h0000_0013);
    do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, TMO - 1, 32'h0BAD_F00D);
    do_access(1'b1, 1'b0, 32'h0000_0034, 32'h0, 20, 32'h7777_7777);
    do_access(1'b1, 1'b1, 32'h0000_0040, 32'h1357_9BDF, 1, 32'h2468_ACE0);
    stray_ack();
    reset_mid_access();

    for (int unsigned i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic        r, w;
      a = $urandom;
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        if (a[1:0] == 2'b00) a[0] = 1'b1;
        do_misaligned(r, w, a);
      end else begin
        a[1:0] = 2'b00;
        do_access(r, w, a, $urandom, $urandom_range(0, TMO + 2), $urandom);
      end
      if ($urandom_range(0, 7) == 0) stray_ack();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
